// File: rtl/bus_master_if_if.sv
// Bus-side signal bundle for one master port on the shared bus.
// The master drives request/strobe/address/data and observes grant, ready and read data.
interface bus_master_if_if;
  logic        bus_req_;
  logic        bus_grnt_;
  logic [29:0] bus_addr;
  logic        bus_as_;
  logic        bus_rw;
  logic [31:0] bus_wr_data;
  logic [31:0] bus_rd_data;
  logic        bus_rdy_;

  modport master (
    output bus_req_,
    output bus_addr,
    output bus_as_,
    output bus_rw,
    output bus_wr_data,
    input  bus_grnt_,
    input  bus_rd_data,
    input  bus_rdy_
  );

  modport slave (
    input  bus_req_,
    input  bus_addr,
    input  bus_as_,
    input  bus_rw,
    input  bus_wr_data,
    output bus_grnt_,
    output bus_rd_data,
    output bus_rdy_
  );
endinterface

// File: rtl/bus_master_if.sv
// CPU-side bus master: turns one load/store request into a request / grant /
// strobe / ready bus transaction, stalls the pipeline while it is in flight and
// aborts a hung access after TIMEOUT cycles in ACCESS with a one-cycle error.
module bus_master_if #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic [29:0]           cpu_addr,
  input  logic                  cpu_rw,
  input  logic [31:0]           cpu_wr_data,
  input  logic                  cpu_stall,
  input  logic                  cpu_flush,
  output logic [31:0]           cpu_rd_data,
  output logic                  cpu_busy,
  output logic                  cpu_err,
  bus_master_if_if.master       bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REQ    = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_STALL  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             req_reg;
  logic             as_reg;
  logic             rw_reg;
  logic [29:0]      addr_reg;
  logic [31:0]      wdata_reg;
  logic [31:0]      rd_reg;

  logic             start;
  logic             ready;
  logic             timeout;

  // Bus strobes and address/data come straight from registers so they never glitch.
  assign bus.bus_req_    = req_reg;
  assign bus.bus_as_     = as_reg;
  assign bus.bus_rw      = rw_reg;
  assign bus.bus_addr    = addr_reg;
  assign bus.bus_wr_data = wdata_reg;

  // Qualify the shared ready with our own ACCESS state; other masters' ready is ignored.
  always_comb begin
    start   = (state == ST_IDLE) && cpu_req && !cpu_flush;
    ready   = (state == ST_ACCESS) && !bus.bus_rdy_;
    timeout = (state == ST_ACCESS) && bus.bus_rdy_ && (cnt == CNT_LAST);
  end

  // Pipeline stall request, error pulse and read-data bypass in the ready cycle.
  always_comb begin
    cpu_busy    = 1'b0;
    cpu_err     = timeout;
    cpu_rd_data = rd_reg;
    case (state)
      ST_IDLE:   cpu_busy = start;
      ST_REQ:    cpu_busy = 1'b1;
      ST_ACCESS: cpu_busy = !(ready || timeout);
      ST_STALL:  cpu_busy = 1'b0;
      default:   cpu_busy = 1'b0;
    endcase
    if (ready && rw_reg) begin
      cpu_rd_data = bus.bus_rd_data;
    end else begin
      cpu_rd_data = rd_reg;
    end
  end

  // Transaction sequencer: latch request, wait grant, strobe, wait ready or time out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      req_reg   <= 1'b1;
      as_reg    <= 1'b1;
      rw_reg    <= 1'b1;
      addr_reg  <= 30'd0;
      wdata_reg <= 32'd0;
      rd_reg    <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            addr_reg  <= cpu_addr;
            rw_reg    <= cpu_rw;
            wdata_reg <= cpu_wr_data;
            req_reg   <= 1'b0;
            state     <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (!bus.bus_grnt_) begin
            as_reg <= 1'b0;
            cnt    <= '0;
            state  <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          as_reg <= 1'b1;
          if (ready || timeout) begin
            // Completion and timeout release the bus the same way.
            if (timeout) begin
              rd_reg <= 32'd0;
            end else if (rw_reg) begin
              rd_reg <= bus.bus_rd_data;
            end
            req_reg   <= 1'b1;
            rw_reg    <= 1'b1;
            addr_reg  <= 30'd0;
            wdata_reg <= 32'd0;
            state     <= cpu_stall ? ST_STALL : ST_IDLE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        ST_STALL: begin
          if (!cpu_stall) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
